// File: rtl/sum_recover_sub.sv
// Recovers B = Result - A from a registered sum using a chunked ripple-borrow subtractor.
// Flags negative differences and differences that overflow DATA_W bits.
module sum_recover_sub #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RES_W   = 40,
   parameter int unsigned CHUNK_W = 8
) (
   input  logic              clk,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RES_W-1:0]  Result_in,
   input  logic [DATA_W-1:0] A_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] B_out,
   output logic              err_neg,
   output logic              err_range
);

   localparam int unsigned NCHUNK = RES_W / CHUNK_W;
   localparam int unsigned IDX_W  = $clog2(NCHUNK + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   logic [RES_W-1:0]   r_q;
   logic [RES_W-1:0]   a_q;
   logic [RES_W-1:0]   diff_q;
   logic [RES_W-1:0]   diff_nxt;
   logic [IDX_W-1:0]   idx;
   logic               borrow;
   logic [CHUNK_W:0]   step;
   logic               last;

   // Operands shift right one chunk per cycle; the difference fills in from the top,
   // so after NCHUNK steps it is fully assembled and aligned.
   always_comb begin
      step = {1'b0, r_q[CHUNK_W-1:0]} - {1'b0, a_q[CHUNK_W-1:0]} - (CHUNK_W+1)'(borrow);
      diff_nxt = {step[CHUNK_W-1:0], diff_q[RES_W-1:CHUNK_W]};
      last = (idx == IDX_W'(NCHUNK - 1));
   end

   // Accept only in IDLE and never while reset is held.
   assign in_ready = (state == IDLE) && !nRST;

   always_ff @(posedge clk) begin
      if (nRST) begin
         state     <= IDLE;
         r_q       <= '0;
         a_q       <= '0;
         diff_q    <= '0;
         idx       <= '0;
         borrow    <= 1'b0;
         out_valid <= 1'b0;
         B_out     <= '0;
         err_neg   <= 1'b0;
         err_range <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  r_q    <= Result_in;
                  a_q    <= RES_W'(A_in);
                  diff_q <= '0;
                  idx    <= '0;
                  borrow <= 1'b0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               r_q    <= r_q >> CHUNK_W;
               a_q    <= a_q >> CHUNK_W;
               diff_q <= diff_nxt;
               borrow <= step[CHUNK_W];
               idx    <= idx + IDX_W'(1);
               if (last) begin
                  B_out     <= diff_nxt[DATA_W-1:0];
                  err_neg   <= step[CHUNK_W];
                  err_range <= !step[CHUNK_W] && (|(diff_nxt >> DATA_W));
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_recover_sub.sv
// Scoreboard bench for sum_recover_sub: directed vectors queue expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_sum_recover_sub;

   logic        clk = 1'b0;
   logic        nRST;
   logic        in_valid;
   logic        in_ready;
   logic [39:0] Result_in;
   logic [31:0] A_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] B_out;
   logic        err_neg;
   logic        err_range;

   typedef struct {
      logic [31:0] b;
      logic        neg;
      logic        rng;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   sum_recover_sub dut (
      .clk       (clk),
      .nRST      (nRST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Result_in (Result_in),
      .A_in      (A_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .B_out     (B_out),
      .err_neg   (err_neg),
      .err_range (err_range)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!nRST && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got B=%h neg=%b rng=%b expected none", B_out, err_neg, err_range);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (B_out !== e.b || err_neg !== e.neg || err_range !== e.rng) begin
               errors++;
               $display("FAIL result: got B=%h neg=%b rng=%b expected B=%h neg=%b rng=%b",
                        B_out, err_neg, err_range, e.b, e.neg, e.rng);
            end
         end
      end
   end

   task automatic send(input logic [39:0] r, input logic [31:0] a, input bit push,
                       input logic [31:0] eb, input logic en, input logic er);
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      Result_in = r;
      A_in      = a;
      in_valid  = 1'b1;
      if (push) exp_q.push_back('{b: eb, neg: en, rng: er});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin ok = 1; break; end
      end
      if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      nRST      = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      Result_in = '0;
      A_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {out_valid, B_out, err_neg, err_range, in_ready}, 64'd0);
      nRST = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      // Basic subtraction with exact latency.
      send(40'h00_0000_0005, 32'd3, 1, 32'd2, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1 chk("latency_not_yet", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1 chk("latency_valid", 64'(out_valid), 64'd1);
      wait_empty();

      send(40'h01_0000_0000, 32'hFFFF_FFFF, 1, 32'd1, 1'b0, 1'b0);
      wait_empty();
      send(40'h00_0000_0002, 32'd5, 1, 32'hFFFF_FFFD, 1'b1, 1'b0);
      wait_empty();
      send(40'h12_0000_0000, 32'd0, 1, 32'd0, 1'b0, 1'b1);
      wait_empty();
      send(40'hFF_FFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd0, 1'b0, 1'b1);
      wait_empty();
      send(40'h00_8000_0100, 32'h0000_01FF, 1, 32'h7FFF_FF01, 1'b0, 1'b0);
      wait_empty();

      // Output stall with in_valid held through BUSY and DONE.
      send(40'd20, 32'd7, 1, 32'd13, 1'b0, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      Result_in = 40'd100;
      A_in      = 32'd1;
      begin
         bit ok = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
         end
         if (!ok) chk("stall_valid_timeout", 64'(out_valid), 64'd1);
      end
      for (int i = 0; i < 10; i++) begin
         chk("stall_hold", {out_valid, B_out, err_neg, err_range, in_ready},
             {1'b1, 32'd13, 1'b0, 1'b0, 1'b0});
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("after_handshake_ready", {out_valid, in_ready}, {1'b0, 1'b1});
      exp_q.push_back('{b: 32'd99, neg: 1'b0, rng: 1'b0});
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("held_accepted", 64'(in_ready), 64'd0);
      wait_empty();

      // Reset on the second BUSY cycle drops the op.
      send(40'h55, 32'h11, 0, 32'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1 nRST = 1'b1;
      @(posedge clk);
      #1 chk("abort_outputs", {out_valid, B_out, err_neg, err_range, in_ready}, 64'd0);
      nRST = 1'b0;
      @(negedge clk);
      chk("abort_idle", 64'(in_ready), 64'd1);
      send(40'd10, 32'd4, 1, 32'd6, 1'b0, 1'b0);
      wait_empty();
      repeat (20) @(posedge clk);
      chk("queue_empty_end", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
